// File: rtl/vram_pkg.sv
// Shared types and defaults for the VDP-to-block-RAM VRAM controller.
// Counter width covers the largest legal read latency (7).
package vram_pkg;

    localparam int VRAM_ADDR_W   = 15;
    localparam int VRAM_READ_LAT = 2;
    localparam int VRAM_CNT_W    = 3;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        ACK,
        RELEASE
    } vram_state_t;

endpackage

// File: rtl/vram_ctrl.sv
// Turns the VDP's strobe-style VRAM request into timed accesses on two 8-bit
// block-RAM ports (A = upper byte, B = lower byte) and returns VRAM_DTACK_N.
module vram_ctrl
    import vram_pkg::*;
#(
    parameter int ADDR_W   = VRAM_ADDR_W,
    parameter int READ_LAT = VRAM_READ_LAT
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              VRAM_SEL,
    input  logic [ADDR_W-1:0] VRAM_ADDR,
    input  logic              VRAM_UB_N,
    input  logic              VRAM_LB_N,
    input  logic              VRAM_WE_N,
    input  logic [15:0]       VRAM_DI,
    output logic [15:0]       VRAM_DO,
    output logic              VRAM_DTACK_N,
    output logic [ADDR_W:0]   RAM_ADDR_A,
    output logic [ADDR_W:0]   RAM_ADDR_B,
    output logic              RAM_EN_A,
    output logic              RAM_EN_B,
    output logic              RAM_WE_A,
    output logic              RAM_WE_B,
    output logic [7:0]        RAM_DIN_A,
    output logic [7:0]        RAM_DIN_B,
    input  logic [7:0]        RAM_DOUT_A,
    input  logic [7:0]        RAM_DOUT_B
);

    vram_state_t           r_state;
    vram_state_t           w_next;
    logic [ADDR_W-1:0]     r_addr;
    logic                  r_ub;
    logic                  r_lb;
    logic                  r_wr;
    logic [15:0]           r_di;
    logic [VRAM_CNT_W-1:0] r_cnt;
    logic                  r_cap_pend;
    logic [15:0]           r_do;
    logic                  r_dtack_n;

    logic                  w_en_a;
    logic                  w_en_b;
    logic                  w_we_a;
    logic                  w_we_b;
    logic                  w_capture;
    logic                  w_accept;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (VRAM_SEL) begin
                    w_next = (VRAM_UB_N && VRAM_LB_N) ? ACK : ISSUE;
                end
            end
            ISSUE: begin
                if (!VRAM_SEL) begin
                    w_next = RELEASE;
                end else if (r_wr || (READ_LAT == 1)) begin
                    w_next = ACK;
                end else begin
                    w_next = WAIT;
                end
            end
            WAIT: begin
                if (!VRAM_SEL) begin
                    w_next = RELEASE;
                end else if (r_cnt == '0) begin
                    w_next = ACK;
                end
            end
            ACK: begin
                if (!VRAM_SEL) begin
                    w_next = IDLE;
                end
            end
            RELEASE: w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // A 1-cycle-latency read goes ISSUE->ACK and captures in its first ACK cycle.
    always_comb begin
        w_accept  = (r_state == IDLE) && VRAM_SEL;
        w_en_a    = (r_state == ISSUE) && r_ub;
        w_en_b    = (r_state == ISSUE) && r_lb;
        w_we_a    = w_en_a && r_wr;
        w_we_b    = w_en_b && r_wr;
        w_capture = ((r_state == WAIT) && VRAM_SEL && (r_cnt == '0)) ||
                    ((r_state == ACK) && r_cap_pend);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_addr     <= '0;
            r_ub       <= 1'b0;
            r_lb       <= 1'b0;
            r_wr       <= 1'b0;
            r_di       <= '0;
            r_cnt      <= '0;
            r_cap_pend <= 1'b0;
            r_do       <= '0;
            r_dtack_n  <= 1'b1;
        end else begin
            if (w_accept) begin
                r_addr <= VRAM_ADDR;
                r_ub   <= !VRAM_UB_N;
                r_lb   <= !VRAM_LB_N;
                r_wr   <= !VRAM_WE_N;
                r_di   <= VRAM_DI;
            end
            if (r_state == ISSUE) begin
                r_cnt <= VRAM_CNT_W'(READ_LAT - 1);
            end else if ((r_state == WAIT) && (r_cnt != '0)) begin
                r_cnt <= r_cnt - 1'b1;
            end
            r_cap_pend <= (r_state == ISSUE) && !r_wr && VRAM_SEL && (READ_LAT == 1);
            if (w_capture) begin
                r_do <= {r_ub ? RAM_DOUT_A : 8'h00, r_lb ? RAM_DOUT_B : 8'h00};
            end
            // Acknowledge lags ACK entry by one cycle and drops the cycle after SEL falls.
            r_dtack_n <= !((r_state == ACK) && VRAM_SEL);
        end
    end

    assign VRAM_DO      = r_do;
    assign VRAM_DTACK_N = r_dtack_n;
    assign RAM_ADDR_A   = {r_addr, 1'b0};
    assign RAM_ADDR_B   = {r_addr, 1'b1};
    assign RAM_EN_A     = w_en_a;
    assign RAM_EN_B     = w_en_b;
    assign RAM_WE_A     = w_we_a;
    assign RAM_WE_B     = w_we_b;
    assign RAM_DIN_A    = r_di[15:8];
    assign RAM_DIN_B    = r_di[7:0];

endmodule

// File: tb/tb_vram_ctrl.sv
// Directed bench for vram_ctrl with a two-cycle-latency byte RAM model.
module tb_vram_ctrl;

    logic        CLK;
    logic        RST_N;
    logic        VRAM_SEL;
    logic [14:0] VRAM_ADDR;
    logic        VRAM_UB_N;
    logic        VRAM_LB_N;
    logic        VRAM_WE_N;
    logic [15:0] VRAM_DI;
    logic [15:0] VRAM_DO;
    logic        VRAM_DTACK_N;
    logic [15:0] RAM_ADDR_A;
    logic [15:0] RAM_ADDR_B;
    logic        RAM_EN_A;
    logic        RAM_EN_B;
    logic        RAM_WE_A;
    logic        RAM_WE_B;
    logic [7:0]  RAM_DIN_A;
    logic [7:0]  RAM_DIN_B;
    logic [7:0]  RAM_DOUT_A;
    logic [7:0]  RAM_DOUT_B;

    int tests = 0;
    int fails = 0;

    vram_ctrl #(.ADDR_W(15), .READ_LAT(2)) dut (
        .CLK(CLK), .RST_N(RST_N), .VRAM_SEL(VRAM_SEL), .VRAM_ADDR(VRAM_ADDR),
        .VRAM_UB_N(VRAM_UB_N), .VRAM_LB_N(VRAM_LB_N), .VRAM_WE_N(VRAM_WE_N),
        .VRAM_DI(VRAM_DI), .VRAM_DO(VRAM_DO), .VRAM_DTACK_N(VRAM_DTACK_N),
        .RAM_ADDR_A(RAM_ADDR_A), .RAM_ADDR_B(RAM_ADDR_B),
        .RAM_EN_A(RAM_EN_A), .RAM_EN_B(RAM_EN_B),
        .RAM_WE_A(RAM_WE_A), .RAM_WE_B(RAM_WE_B),
        .RAM_DIN_A(RAM_DIN_A), .RAM_DIN_B(RAM_DIN_B),
        .RAM_DOUT_A(RAM_DOUT_A), .RAM_DOUT_B(RAM_DOUT_B)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Byte RAM model: low 8 address bits, read data appears two edges after EN.
    logic [7:0] mem [0:255] = '{default: 8'h00};
    logic [7:0] s1_a = 8'h00, s1_b = 8'h00, s2_a = 8'h00, s2_b = 8'h00;
    always @(posedge CLK) begin
        if (RAM_EN_A) begin
            if (RAM_WE_A) mem[RAM_ADDR_A[7:0]] <= RAM_DIN_A;
            else          s1_a <= mem[RAM_ADDR_A[7:0]];
        end
        if (RAM_EN_B) begin
            if (RAM_WE_B) mem[RAM_ADDR_B[7:0]] <= RAM_DIN_B;
            else          s1_b <= mem[RAM_ADDR_B[7:0]];
        end
        s2_a <= s1_a;
        s2_b <= s1_b;
    end
    assign RAM_DOUT_A = s2_a;
    assign RAM_DOUT_B = s2_b;

    // Raises SEL and waits for DTACK_N; lat counts edges after the sampling edge, -1 on timeout.
    task automatic do_req(input logic we_n, input logic ub_n, input logic lb_n,
                          input logic [14:0] addr, input logic [15:0] di,
                          output int lat, output int ena, output int enb,
                          output int wea, output int web,
                          output logic [15:0] ad_a, output logic [15:0] ad_b,
                          output logic [7:0] da, output logic [7:0] db);
        bit acked;
        @(negedge CLK);
        VRAM_WE_N = we_n; VRAM_UB_N = ub_n; VRAM_LB_N = lb_n;
        VRAM_ADDR = addr; VRAM_DI = di; VRAM_SEL = 1'b1;
        lat = 0; ena = 0; enb = 0; wea = 0; web = 0;
        ad_a = 16'hxxxx; ad_b = 16'hxxxx; da = 8'hxx; db = 8'hxx;
        acked = 1'b0;
        @(posedge CLK);
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            if (RAM_EN_A) begin ena++; ad_a = RAM_ADDR_A; end
            if (RAM_EN_B) begin enb++; ad_b = RAM_ADDR_B; end
            if (RAM_WE_A) begin wea++; da = RAM_DIN_A; end
            if (RAM_WE_B) begin web++; db = RAM_DIN_B; end
            if (VRAM_DTACK_N === 1'b0) begin
                acked = 1'b1;
                break;
            end
            @(posedge CLK);
            lat++;
        end
        if (!acked) lat = -1;
    endtask

    int lat, ena, enb, wea, web;
    logic [15:0] ad_a, ad_b;
    logic [7:0] da, db;

    task automatic test_reset();
        repeat (2) @(posedge CLK);
        #1;
        tests++;
        if ({VRAM_DTACK_N, VRAM_DO} !== {1'b1, 16'h0000}) begin
            fails++; $display("FAIL reset_dtack_do: got %b/%h expected 1/0000", VRAM_DTACK_N, VRAM_DO);
        end
        tests++;
        if ({RAM_EN_A, RAM_EN_B, RAM_WE_A, RAM_WE_B, RAM_ADDR_A, RAM_DIN_A, RAM_DIN_B} !== 36'h0_0000_0000) begin
            fails++; $display("FAIL reset_ram: got en=%b%b we=%b%b addr=%h din=%h%h expected zeros",
                              RAM_EN_A, RAM_EN_B, RAM_WE_A, RAM_WE_B, RAM_ADDR_A, RAM_DIN_A, RAM_DIN_B);
        end
        @(negedge CLK);
        RST_N = 1'b1;
    endtask

    task automatic drop_sel(input string name);
        VRAM_SEL = 1'b0;
        @(negedge CLK);
        tests++;
        if (VRAM_DTACK_N !== 1'b1) begin
            fails++; $display("FAIL %s_release: got dtack_n=%b expected 1", name, VRAM_DTACK_N);
        end
    endtask

    task automatic test_write_read();
        do_req(1'b0, 1'b0, 1'b0, 15'h0010, 16'hBEEF, lat, ena, enb, wea, web, ad_a, ad_b, da, db);
        tests++;
        if (lat !== 2) begin fails++; $display("FAIL wr_latency: got %0d expected 2", lat); end
        tests++;
        if ({wea, web} !== {32'd1, 32'd1}) begin
            fails++; $display("FAIL wr_we_pulse: got %0d/%0d expected 1/1", wea, web);
        end
        tests++;
        if ({ad_a, ad_b} !== {16'h0020, 16'h0021}) begin
            fails++; $display("FAIL wr_addr: got %h/%h expected 0020/0021", ad_a, ad_b);
        end
        tests++;
        if ({da, db} !== 16'hBEEF) begin
            fails++; $display("FAIL wr_din: got %h%h expected BEEF", da, db);
        end
        drop_sel("wr");
        do_req(1'b1, 1'b0, 1'b0, 15'h0010, 16'h0000, lat, ena, enb, wea, web, ad_a, ad_b, da, db);
        tests++;
        if (lat !== 4) begin fails++; $display("FAIL rd_latency: got %0d expected 4", lat); end
        tests++;
        if ({ena, enb, wea, web} !== {32'd1, 32'd1, 32'd0, 32'd0}) begin
            fails++; $display("FAIL rd_enables: got en=%0d/%0d we=%0d/%0d expected 1/1 0/0", ena, enb, wea, web);
        end
        tests++;
        if (VRAM_DO !== 16'hBEEF) begin fails++; $display("FAIL rd_data: got %h expected BEEF", VRAM_DO); end
        drop_sel("rd");
    endtask

    task automatic test_abort();
        int dt_low;
        @(negedge CLK);
        VRAM_WE_N = 1'b1; VRAM_UB_N = 1'b0; VRAM_LB_N = 1'b0;
        VRAM_ADDR = 15'h0020; VRAM_SEL = 1'b1;
        @(posedge CLK);
        @(posedge CLK);
        @(negedge CLK);
        VRAM_SEL = 1'b0;
        dt_low = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK);
            if (VRAM_DTACK_N !== 1'b1) dt_low++;
        end
        tests++;
        if (dt_low !== 0) begin fails++; $display("FAIL abort_dtack: got %0d low cycles expected 0", dt_low); end
        tests++;
        if (VRAM_DO !== 16'hBEEF) begin fails++; $display("FAIL abort_do_kept: got %h expected BEEF", VRAM_DO); end
        do_req(1'b1, 1'b0, 1'b0, 15'h0020, 16'h0000, lat, ena, enb, wea, web, ad_a, ad_b, da, db);
        tests++;
        if ({lat, VRAM_DO} !== {32'd4, 16'h0000}) begin
            fails++; $display("FAIL abort_next_req: got lat=%0d do=%h expected 4/0000", lat, VRAM_DO);
        end
        drop_sel("abort");
    endtask

    task automatic test_lanes();
        do_req(1'b0, 1'b0, 1'b1, 15'h0010, 16'h1234, lat, ena, enb, wea, web, ad_a, ad_b, da, db);
        tests++;
        if ({lat, wea, web, ena, enb} !== {32'd2, 32'd1, 32'd0, 32'd1, 32'd0}) begin
            fails++; $display("FAIL upper_wr: got lat=%0d we=%0d/%0d en=%0d/%0d expected 2 1/0 1/0", lat, wea, web, ena, enb);
        end
        tests++;
        if (da !== 8'h12) begin fails++; $display("FAIL upper_din: got %h expected 12", da); end
        drop_sel("upper_wr");
        do_req(1'b1, 1'b0, 1'b0, 15'h0010, 16'h0000, lat, ena, enb, wea, web, ad_a, ad_b, da, db);
        tests++;
        if (VRAM_DO !== 16'h12EF) begin fails++; $display("FAIL full_rd: got %h expected 12EF", VRAM_DO); end
        drop_sel("full_rd");
        do_req(1'b1, 1'b1, 1'b0, 15'h0010, 16'h0000, lat, ena, enb, wea, web, ad_a, ad_b, da, db);
        tests++;
        if ({VRAM_DO, ena, enb} !== {16'h00EF, 32'd0, 32'd1}) begin
            fails++; $display("FAIL lower_rd: got do=%h en=%0d/%0d expected 00EF 0/1", VRAM_DO, ena, enb);
        end
        drop_sel("lower_rd");
    endtask

    task automatic test_hold();
        int bad;
        do_req(1'b1, 1'b0, 1'b0, 15'h0010, 16'h0000, lat, ena, enb, wea, web, ad_a, ad_b, da, db);
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            if (VRAM_DTACK_N !== 1'b0 || RAM_EN_A !== 1'b0 || RAM_EN_B !== 1'b0) bad++;
        end
        tests++;
        if (bad !== 0) begin fails++; $display("FAIL hold_ack: got %0d bad cycles expected 0", bad); end
        drop_sel("hold");
        do_req(1'b1, 1'b0, 1'b0, 15'h0010, 16'h0000, lat, ena, enb, wea, web, ad_a, ad_b, da, db);
        tests++;
        if ({lat, VRAM_DO} !== {32'd4, 16'h12EF}) begin
            fails++; $display("FAIL hold_next_req: got lat=%0d do=%h expected 4/12EF", lat, VRAM_DO);
        end
        drop_sel("hold_next");
    endtask

    task automatic test_null();
        do_req(1'b0, 1'b1, 1'b1, 15'h0010, 16'h5555, lat, ena, enb, wea, web, ad_a, ad_b, da, db);
        tests++;
        if ({lat, ena, enb} !== {32'd1, 32'd0, 32'd0}) begin
            fails++; $display("FAIL null_req: got lat=%0d en=%0d/%0d expected 1 0/0", lat, ena, enb);
        end
        drop_sel("null");
    endtask

    task automatic test_reset_mid();
        @(negedge CLK);
        VRAM_WE_N = 1'b1; VRAM_UB_N = 1'b0; VRAM_LB_N = 1'b0;
        VRAM_ADDR = 15'h0010; VRAM_SEL = 1'b1;
        @(posedge CLK);
        @(posedge CLK);
        #2;
        RST_N = 1'b0;
        #1;
        tests++;
        if ({VRAM_DTACK_N, VRAM_DO} !== {1'b1, 16'h0000}) begin
            fails++; $display("FAIL rst_mid_out: got %b/%h expected 1/0000", VRAM_DTACK_N, VRAM_DO);
        end
        tests++;
        if ({RAM_EN_A, RAM_EN_B, RAM_ADDR_A, RAM_ADDR_B} !== 34'h0_0000_0001) begin
            fails++; $display("FAIL rst_mid_ram: got en=%b%b addr=%h/%h expected 00 0000/0001",
                              RAM_EN_A, RAM_EN_B, RAM_ADDR_A, RAM_ADDR_B);
        end
        VRAM_SEL = 1'b0;
        @(negedge CLK);
        RST_N = 1'b1;
        do_req(1'b1, 1'b0, 1'b0, 15'h0010, 16'h0000, lat, ena, enb, wea, web, ad_a, ad_b, da, db);
        tests++;
        if ({lat, VRAM_DO} !== {32'd4, 16'h12EF}) begin
            fails++; $display("FAIL rst_recover: got lat=%0d do=%h expected 4/12EF", lat, VRAM_DO);
        end
        drop_sel("rst_recover");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        RST_N = 1'b0; VRAM_SEL = 1'b0; VRAM_ADDR = '0;
        VRAM_UB_N = 1'b1; VRAM_LB_N = 1'b1; VRAM_WE_N = 1'b1; VRAM_DI = '0;
        test_reset();
        test_write_read();
        test_abort();
        test_lanes();
        test_hold();
        test_null();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
